// File: rtl/rwb_pkg.sv
// Shared types and default sizing for the register write-back queue.
package rwb_pkg;

  localparam int RWB_DEPTH = 4;
  localparam int RWB_AW    = 5;
  localparam int RWB_DW    = 32;

  // One pending register-file write.
  typedef struct packed {
    logic [RWB_AW-1:0] addr;
    logic [RWB_DW-1:0] data;
  } rwb_entry_t;

endpackage

// File: rtl/reg_wb_queue_if.sv
// Handshake, register-file write port, occupancy and bypass lookup
// signals of the write-back queue. The slave modport is the queue's view.
interface reg_wb_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 3
);
  logic          memV;
  logic [AW-1:0] memA;
  logic [DW-1:0] memD;
  logic          memRdy;
  logic          aluV;
  logic [AW-1:0] aluA;
  logic [DW-1:0] aluD;
  logic          aluRdy;
  logic          regW;
  logic [AW-1:0] wrA;
  logic [DW-1:0] wrD;
  logic [CW-1:0] count;
  logic [AW-1:0] byA;
  logic          byHit;
  logic [DW-1:0] byD;

  modport slave (
    input  memV, memA, memD, aluV, aluA, aluD, byA,
    output memRdy, aluRdy, regW, wrA, wrD, count, byHit, byD
  );

  modport master (
    output memV, memA, memD, aluV, aluA, aluD, byA,
    input  memRdy, aluRdy, regW, wrA, wrD, count, byHit, byD
  );
endinterface

// File: rtl/rwb_fifo.sv
// Dual-push, single-pop FIFO. Port 0 is the older entry when both push on
// the same edge; port 1 lands in the slot right after it. Contents, read
// pointer and count are exported so the top can search pending entries.
module rwb_fifo import rwb_pkg::*; #(
  parameter int  DEPTH   = RWB_DEPTH,
  parameter type entry_t = rwb_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push0_i,
  input  entry_t               din0_i,
  input  logic                 push1_i,
  input  entry_t               din1_i,
  input  logic                 pop_i,
  output entry_t               head_o,
  output logic [CW-1:0]        count_o,
  output logic [PW-1:0]        rd_ptr_o,
  output entry_t [DEPTH-1:0]   mem_o
);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      slot1_s;
  logic [CW-1:0]      count_q, count_d;
  entry_t [DEPTH-1:0] mem_q;

  // Next pointers and occupancy; pointer arithmetic wraps naturally.
  always_comb begin
    slot1_s  = wr_ptr_q + PW'(push0_i);
    wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q - CW'(pop_i) + CW'(push0_i) + CW'(push1_i);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; the older request takes the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      if (push0_i) begin
        mem_q[wr_ptr_q] <= din0_i;
      end
      if (push1_i) begin
        mem_q[slot1_s] <= din1_i;
      end
    end
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign rd_ptr_o = rd_ptr_q;
  assign mem_o    = mem_q;

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue in front of the register file write port. Accepts load
// and ALU results (load is older), drops writes to register 0, retires one
// entry per cycle. Optional bypass search enabled by RWB_BYPASS_EN.
module reg_wb_queue import rwb_pkg::*; #(
  parameter int DEPTH = RWB_DEPTH,
  parameter int AW    = RWB_AW,
  parameter int DW    = RWB_DW
) (
  input logic           clk,
  input logic           rst_n,
  reg_wb_queue_if.slave wb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = CW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic               regw_s;
  logic [CW-1:0]      count_s;
  logic [FW-1:0]      free_s;
  logic               mem_rdy_s, alu_rdy_s;
  logic               push_mem_s, push_alu_s;
  entry_t             head_s;
  entry_t             din_mem_s, din_alu_s;
  entry_t [DEPTH-1:0] mem_s;
  logic [PW-1:0]      rd_ptr_s;
  logic               by_hit_s;
  logic [DW-1:0]      by_d_s;

  // Ready depends only on occupancy, the head pop and whether a load is offered.
  always_comb begin
    regw_s     = (count_s != '0);
    free_s     = FW'(DEPTH) - {1'b0, count_s} + FW'(regw_s);
    mem_rdy_s  = (free_s >= FW'(1));
    alu_rdy_s  = (free_s >= (wb.memV ? FW'(2) : FW'(1)));
    push_mem_s = wb.memV && mem_rdy_s && (wb.memA != '0);
    push_alu_s = wb.aluV && alu_rdy_s && (wb.aluA != '0);
    din_mem_s  = '{addr: wb.memA, data: wb.memD};
    din_alu_s  = '{addr: wb.aluA, data: wb.aluD};
  end

  rwb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push0_i  (push_mem_s),
    .din0_i   (din_mem_s),
    .push1_i  (push_alu_s),
    .din1_i   (din_alu_s),
    .pop_i    (regw_s),
    .head_o   (head_s),
    .count_o  (count_s),
    .rd_ptr_o (rd_ptr_s),
    .mem_o    (mem_s)
  );

`ifdef RWB_BYPASS_EN
  logic [PW-1:0] idx_s;

  // Walk pending entries oldest to youngest so the youngest match wins.
  always_comb begin
    by_hit_s = 1'b0;
    by_d_s   = '0;
    idx_s    = rd_ptr_s;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = rd_ptr_s + PW'(i);
      if ((CW'(i) < count_s) && (wb.byA != '0) && (mem_s[idx_s].addr == wb.byA)) begin
        by_hit_s = 1'b1;
        by_d_s   = mem_s[idx_s].data;
      end else begin
        by_hit_s = by_hit_s;
      end
    end
  end
`else
  logic unused_ok;

  // Without bypass the lookup port and storage view are not needed.
  assign by_hit_s  = 1'b0;
  assign by_d_s    = '0;
  assign unused_ok = ^{mem_s, rd_ptr_s, wb.byA};
`endif

  assign wb.memRdy = mem_rdy_s;
  assign wb.aluRdy = alu_rdy_s;
  assign wb.regW   = regw_s;
  assign wb.wrA    = regw_s ? head_s.addr : '0;
  assign wb.wrD    = regw_s ? head_s.data : '0;
  assign wb.count  = count_s;
  assign wb.byHit  = by_hit_s;
  assign wb.byD    = by_d_s;

endmodule
